// File: rtl/bj_episode_driver_if.sv
// -----------------------------------------------------------------------------
// bj_episode_driver_if
// Purpose : Bundles the policy-side handshakes (action in, observation out) and
//           the compute-core request/response bus of bj_episode_driver.
//           Signal names keep the driver's point of view: i_* flow into the
//           driver, o_* flow out of it.
// Modports:
//   master - the episode driver (drives o_*, samples i_*)
//   slave  - the environment: policy plus compute core (drives i_*, samples o_*)
// -----------------------------------------------------------------------------
interface bj_episode_driver_if #(
  parameter int STA_WL = 160,
  parameter int OBS_WL = 32,
  parameter int ACT_WL = 1,
  parameter int RWD_WL = 2
);
  // policy action channel
  logic              i_act_valid;
  logic              o_act_ready;
  logic [ACT_WL-1:0] i_act;
  // policy result channel
  logic              o_obs_valid;
  logic              i_obs_ready;
  logic [OBS_WL-1:0] o_obs;
  logic [RWD_WL-1:0] o_rwd;
  logic              o_done;
  // compute core request
  logic              o_core_ena;
  logic [STA_WL-1:0] o_core_sta;
  logic [ACT_WL-1:0] o_core_act;
  // compute core response
  logic [STA_WL-1:0] i_core_sta;
  logic [OBS_WL-1:0] i_core_obs;
  logic [RWD_WL-1:0] i_core_rwd;
  logic              i_core_done;
  logic              i_core_valid;

  modport master (
    input  i_act_valid, i_act, i_obs_ready,
    input  i_core_sta, i_core_obs, i_core_rwd, i_core_done, i_core_valid,
    output o_act_ready, o_obs_valid, o_obs, o_rwd, o_done,
    output o_core_ena, o_core_sta, o_core_act
  );

  modport slave (
    output i_act_valid, i_act, i_obs_ready,
    output i_core_sta, i_core_obs, i_core_rwd, i_core_done, i_core_valid,
    input  o_act_ready, o_obs_valid, o_obs, o_rwd, o_done,
    input  o_core_ena, o_core_sta, o_core_act
  );
endinterface

// File: rtl/bj_episode_driver.sv
// -----------------------------------------------------------------------------
// bj_episode_driver
// Purpose : Episode-level initiator for the BlackJack compute core. Deals a
//           fresh card state from a 16-bit LFSR at every episode start, shows
//           the initial observation to the policy, forwards each policy action
//           with the current state to the core, and returns the core's
//           observation/reward/done to the policy. Restarts after done.
// Ports   :
//   i_clk    - clock
//   i_rstn   - asynchronous active-low reset
//   i_ena    - run enable (sampled in IDLE and at episode end only)
//   o_ep_cnt - completed-episode counter, wraps
//   bus      - policy handshakes + core request/response (master modport)
// -----------------------------------------------------------------------------
module bj_episode_driver #(
  parameter int          STA_WL              = 160,
  parameter int          OBS_WL              = 32,
  parameter int          CARD_WL             = 4,
  parameter int          PLAYER_MAX_CARD_NUM = 21,
  parameter int          DEALER_MAX_CARD_NUM = 17,
  parameter int          ACT_WL              = 1,
  parameter int          RWD_WL              = 2,
  parameter logic [15:0] SEED                = 16'hACE1  // must be nonzero
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_ena,
  output logic [15:0]          o_ep_cnt,
  bj_episode_driver_if.master  bus
);

  localparam int NUM_CARDS  = PLAYER_MAX_CARD_NUM + DEALER_MAX_CARD_NUM;
  localparam int CNT_WL     = $clog2(NUM_CARDS + 1);
  // dealer slots start right after the last player slot
  localparam int DEALER_OFS = CARD_WL * PLAYER_MAX_CARD_NUM;

  typedef enum logic [2:0] {
    IDLE,
    DEAL,
    INIT_OBS,
    WAIT_ACT,
    CORE,
    STEP_OBS
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [STA_WL-1:0]   sta_q, sta_d;
  logic [CNT_WL-1:0]   cnt_q, cnt_d;
  logic [ACT_WL-1:0]   act_q, act_d;
  logic [OBS_WL-1:0]   obs_q, obs_d;
  logic [RWD_WL-1:0]   rwd_q, rwd_d;
  logic                done_q, done_d;
  logic [15:0]         ep_cnt_q, ep_cnt_d;
  logic                act_ready_q, act_ready_d;
  logic                obs_valid_q, obs_valid_d;
  logic                core_ena_q, core_ena_d;

  // ---------------------------------------------------------------------------
  // Card draw: low nibble of the LFSR, 1..13 accepted, faces clamp to 10.
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right with feedback into
  // bit 15 (tap k sits at bit 16-k).
  // ---------------------------------------------------------------------------
  logic [3:0]         draw_r;
  logic               draw_ok;
  logic [CARD_WL-1:0] draw_card;
  logic               lfsr_fb;

  assign draw_r    = lfsr_q[3:0];
  assign draw_ok   = (draw_r != 4'd0) && (draw_r <= 4'd13);
  assign draw_card = (draw_r > 4'd10) ? CARD_WL'(10) : CARD_WL'(draw_r);
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // ---------------------------------------------------------------------------
  // Initial observation from player slots 0/1 and dealer slot 0. Those slots
  // are already filled on the last deal cycle, so the value can be registered
  // on the same edge that enters INIT_OBS.
  // ---------------------------------------------------------------------------
  logic [CARD_WL-1:0] p0, p1, d0;
  logic [4:0]         hand_sum;
  logic               usable_ace;
  logic [OBS_WL-1:0]  init_obs;

  assign p0 = sta_q[0 +: CARD_WL];
  assign p1 = sta_q[CARD_WL +: CARD_WL];
  assign d0 = sta_q[DEALER_OFS +: CARD_WL];

  always_comb begin
    hand_sum   = 5'(p0) + 5'(p1);
    // an ace counts as 11 only if that does not bust the hand
    usable_ace = ((p0 == CARD_WL'(1)) || (p1 == CARD_WL'(1))) && (hand_sum <= 5'd11);
    init_obs   = '0;
    init_obs[0]                 = usable_ace;
    init_obs[1 +: CARD_WL]      = d0;
    init_obs[CARD_WL + 1 +: 5]  = usable_ace ? (hand_sum + 5'd10) : hand_sum;
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    sta_d    = sta_q;
    cnt_d    = '0;
    act_d    = act_q;
    obs_d    = obs_q;
    rwd_d    = rwd_q;
    done_d   = done_q;
    ep_cnt_d = ep_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_ena) state_d = DEAL;
      end
      DEAL: begin
        lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        cnt_d  = cnt_q;
        if (draw_ok) begin
          // player and dealer slots are contiguous, so slot index == cnt
          sta_d[cnt_q * CARD_WL +: CARD_WL] = draw_card;
          cnt_d = cnt_q + CNT_WL'(1);
          if (cnt_q == CNT_WL'(NUM_CARDS - 1)) begin
            state_d = INIT_OBS;
            obs_d   = init_obs;
            rwd_d   = '0;
            done_d  = 1'b0;
          end
        end
      end
      INIT_OBS: begin
        if (bus.i_obs_ready) state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (bus.i_act_valid) begin
          act_d   = bus.i_act;
          state_d = CORE;
        end
      end
      CORE: begin
        if (bus.i_core_valid) begin
          sta_d   = bus.i_core_sta;
          obs_d   = bus.i_core_obs;
          rwd_d   = bus.i_core_rwd;
          done_d  = bus.i_core_done;
          state_d = STEP_OBS;
        end
      end
      STEP_OBS: begin
        if (bus.i_obs_ready) begin
          if (done_q) begin
            ep_cnt_d = ep_cnt_q + 16'd1;
            sta_d    = '0;
            state_d  = i_ena ? DEAL : IDLE;
          end else begin
            state_d = WAIT_ACT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // handshake flags are registered copies of the next state decode
    act_ready_d = (state_d == WAIT_ACT);
    obs_valid_d = (state_d == INIT_OBS) || (state_d == STEP_OBS);
    core_ena_d  = (state_d == CORE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      sta_q       <= '0;
      cnt_q       <= '0;
      act_q       <= '0;
      obs_q       <= '0;
      rwd_q       <= '0;
      done_q      <= 1'b0;
      ep_cnt_q    <= '0;
      act_ready_q <= 1'b0;
      obs_valid_q <= 1'b0;
      core_ena_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      sta_q       <= sta_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      obs_q       <= obs_d;
      rwd_q       <= rwd_d;
      done_q      <= done_d;
      ep_cnt_q    <= ep_cnt_d;
      act_ready_q <= act_ready_d;
      obs_valid_q <= obs_valid_d;
      core_ena_q  <= core_ena_d;
    end
  end

  assign bus.o_act_ready = act_ready_q;
  assign bus.o_obs_valid = obs_valid_q;
  assign bus.o_obs       = obs_q;
  assign bus.o_rwd       = rwd_q;
  assign bus.o_done      = done_q;
  assign bus.o_core_ena  = core_ena_q;
  assign bus.o_core_sta  = sta_q;
  assign bus.o_core_act  = act_q;
  assign o_ep_cnt        = ep_cnt_q;

endmodule

// File: doc/bj_episode_driver.md
# bj_episode_driver

Episode-level initiator for the BlackJack compute core (`Compute_Single`). It deals a fresh card state from an LFSR at every episode start and presents the initial observation to the external policy. It then accepts actions through a valid/ready handshake and issues each action with the current state to the core. It latches the core's next state, observation, reward and done flag and returns them to the policy, restarting the episode automatically after done.

## Interface
- STA_WL, 160, state word width (core i_sta/o_sta)
- OBS_WL, 32, observation width
- CARD_WL, 4, bits per card
- PLAYER_MAX_CARD_NUM, 21, player card slots
- DEALER_MAX_CARD_NUM, 17, dealer card slots
- ACT_WL, 1, action width (HIT=1, STICK=0)
- RWD_WL, 2, reward width (passed through unmodified)
- SEED, 16'hACE1, LFSR reset value, must be nonzero

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; one clock, asynchronous, active-low
- i_ena  in  1  run enable
- i_act_valid  in  1  policy action valid
- o_act_ready  out  1  driver ready for action
- i_act  in  ACT_WL  policy action
- o_obs_valid  out  1  obs/rwd/done valid
- i_obs_ready  in  1  policy accepts result
- o_obs  out  OBS_WL  observation
- o_rwd  out  RWD_WL  reward
- o_done  out  1  episode finished
- o_ep_cnt  out  16  completed-episode count, wraps
- o_core_ena  out  1  core request
- o_core_sta  out  STA_WL  state to core
- o_core_act  out  ACT_WL  action to core
- i_core_sta  in  STA_WL  next state from core
- i_core_obs  in  OBS_WL  observation from core
- i_core_rwd  in  RWD_WL  reward from core
- i_core_done  in  1  done from core
- i_core_valid  in  1  core result valid

## Operation
- **State layout:** bits [83:0] hold the player slots, slot k at [4k+3:4k]. Bits [151:84] hold the dealer slots, slot k at [84+4k+3:84+4k]. Bits [159:152] are zero at deal.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. It advances once per cycle only in DEAL.
- **Draw rule:** r = lfsr[3:0].
  - Accept if r is in 1..13; card = min(r,10).
  - Otherwise reject; no slot is written that cycle.
  - Slots fill in order: player 0..20, then dealer 0..16, for 38 accepted draws.
- **IDLE:** all valids and readies are low. Go to DEAL when i_ena=1.
- **DEAL:** draw until 38 cards are accepted, then go to INIT_OBS.
- **INIT_OBS:** o_obs_valid=1, o_rwd=0, o_done=0.
  - o_obs = {zeros, sum[4:0], dealer slot0[3:0], ace}.
  - s = p0+p1. ace = (p0==1 or p1==1) and s+10<=21. sum = ace ? s+10 : s.
  - On i_obs_ready, go to WAIT_ACT.
- **WAIT_ACT:** o_act_ready=1. On i_act_valid, latch i_act and go to CORE.
- **CORE:** o_core_ena=1, with o_core_sta and o_core_act held stable.
  - On i_core_valid, latch i_core_sta into the state register and latch obs/rwd/done, then go to STEP_OBS.
  - i_core_valid in any other state is ignored.
- **STEP_OBS:** o_obs_valid=1 with the latched values. On i_obs_ready:
  - done=0: go to WAIT_ACT.
  - done=1: o_ep_cnt+1, reset the state register to zero, then go to DEAL if i_ena=1, else IDLE.
- **i_ena:** sampled only in IDLE and at episode end. Deasserting it mid-episode does not abort the episode.
- **Output stability:** o_obs, o_rwd and o_done hold while o_obs_valid=1 and i_obs_ready=0.

## Timing
- **Reset values:** all outputs 0, state register 0, LFSR=SEED, FSM=IDLE. Reset mid-operation aborts immediately, including an outstanding core request.
- **Handshakes:** both transfer on the rising edge when valid and ready are both high. o_act_ready and o_obs_valid are registered.
- **DEAL:** 38 cycles minimum, one cycle per draw including rejects.
- **Action to core:** o_core_ena rises the cycle after the action handshake.
- **Core to result:** o_obs_valid rises the cycle after i_core_valid. o_core_ena falls on that same edge.
- **Zero-wait core:** i_core_valid=1 on the first o_core_ena cycle gives o_obs_valid two cycles after the action handshake.
- **Back-to-back:** a result handshake with done=0 raises o_act_ready on the next cycle.

## Test plan
- **Reset/deal, SEED=16'h0001:** assert reset, then i_ena=1.
  - During reset all outputs are 0.
  - o_core_sta card slots match the LFSR model draw for draw, all 38 cards are in 1..10, and bits [159:152]=0.
  - INIT_OBS is reached at cycle 38 plus the reject count.
- **Initial obs:** for the dealt p0=1, p1=6 (or the bench model's values), o_obs[9:5]=17 and o_obs[0]=1. For p0=10, p1=5: sum 15, ace 0. Dealer slot0 appears at o_obs[4:1].
- **Step, HIT:** core model returns valid 3 cycles after o_core_ena with obs 32'h2A, rwd 2'b00, done 0.
  - o_obs=32'h2A on the following cycle.
  - o_core_sta on the next step equals the returned i_core_sta.
- **Episode end, STICK:** core returns rwd 2'b01, done 1.
  - o_done=1 and o_rwd=1.
  - o_ep_cnt goes 0->1 after the handshake.
  - A new DEAL starts; with i_ena=0 the FSM goes to IDLE instead.
- **Backpressure:** i_obs_ready held low for 5 cycles. o_obs, o_rwd and o_done stay constant; a spurious i_core_valid during this period is ignored.
- **Reset mid-CORE:** assert i_rstn=0 while o_core_ena=1. o_core_ena drops asynchronously; after release the FSM is in IDLE with o_ep_cnt=0.
